// File: rtl/decode_issue_buffer.sv
// Two-entry skid buffer between decode and the ALU stage with a load-use interlock.
// Optional performance counters are enabled by defining DECODE_ISSUE_PERF_EN.
module decode_issue_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned CTRL_W    = 16,
  parameter int unsigned HAZ_STALL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rega_data,
  input  logic [XLEN-1:0]   in_regb_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [RA_W-1:0]   in_rega,
  input  logic [RA_W-1:0]   in_regb,
  input  logic [RA_W-1:0]   in_regd,
  input  logic              in_uses_b,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              ex_valid,
  input  logic              ex_mem_r,
  input  logic [RA_W-1:0]   ex_regd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rega_data,
  output logic [XLEN-1:0]   out_regb_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [RA_W-1:0]   out_rega,
  output logic [RA_W-1:0]   out_regb,
  output logic [RA_W-1:0]   out_regd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_haz_cycles,
  output logic [31:0]       perf_full_cycles
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned SC_W  = 3;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rega_data;
    logic [XLEN-1:0]   regb_data;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rega;
    logic [RA_W-1:0]   regb;
    logic [RA_W-1:0]   regd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head_entry;
  logic            head;
  logic            tail;
  logic [1:0]      count;
  logic [SC_W-1:0] stall_cnt;
  logic            haz_now;
  logic            push;
  logic            pop;

  // Handshake and hazard decode; in_ready never looks at out_ready.
  always_comb begin
    haz_now   = in_valid & ex_valid & ex_mem_r & (ex_regd != '0) &
                ((ex_regd == in_rega) | (in_uses_b & (ex_regd == in_regb)));
    in_ready  = reset & (count != 2'd2) & ~haz_now & (stall_cnt == '0);
    out_valid = (count != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  always_comb begin
    in_entry.pc        = in_pc;
    in_entry.rega_data = in_rega_data;
    in_entry.regb_data = in_regb_data;
    in_entry.imm       = in_imm;
    in_entry.rega      = in_rega;
    in_entry.regb      = in_regb;
    in_entry.regd      = in_regd;
    in_entry.ctrl      = in_ctrl;
    head_entry         = mem[head];
  end

  assign out_pc        = head_entry.pc;
  assign out_rega_data = head_entry.rega_data;
  assign out_regb_data = head_entry.regb_data;
  assign out_imm       = head_entry.imm;
  assign out_rega      = head_entry.rega;
  assign out_regb      = head_entry.regb;
  assign out_regd      = head_entry.regd;
  assign out_ctrl      = head_entry.ctrl;
  assign occupancy     = count;

  // Storage and pointers; flush zeroes entries so a dropped slot reads as a NOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_entry;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= 2'(count + 2'd1);
        2'b01:   count <= 2'(count - 2'd1);
        default: count <= count;
      endcase
    end
  end

  // Interlock: a fresh hazard blocks this cycle plus HAZ_STALL-1 more.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (stall_cnt != '0) begin
      stall_cnt <= SC_W'(stall_cnt - SC_W'(1));
    end else if (haz_now) begin
      stall_cnt <= SC_W'(HAZ_STALL - 1);
    end
  end

`ifdef DECODE_ISSUE_PERF_EN
  logic haz_blocked;
  logic full_seen;

  always_comb begin
    haz_blocked = in_valid & ~in_ready & (haz_now | (stall_cnt != '0));
    full_seen   = in_valid & (count == 2'd2);
  end

  // Saturating counters survive flush and clear only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_haz_cycles  <= '0;
      perf_full_cycles <= '0;
    end else begin
      if (haz_blocked && (perf_haz_cycles != '1))
        perf_haz_cycles <= perf_haz_cycles + 32'd1;
      if (full_seen && (perf_full_cycles != '1))
        perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_decode_issue_buffer;
  localparam int unsigned XLEN = 32, RA_W = 5, CTRL_W = 16, HZ = 2;

  typedef struct packed {
    logic [XLEN-1:0]   pc, a_data, b_data, imm;
    logic [RA_W-1:0]   ra, rb, rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic clk, reset, flush, in_valid, in_ready, in_uses_b;
  logic [XLEN-1:0] in_pc, in_rega_data, in_regb_data, in_imm;
  logic [RA_W-1:0] in_rega, in_regb, in_regd, ex_regd;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic ex_valid, ex_mem_r, out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_rega_data, out_regb_data, out_imm;
  logic [RA_W-1:0] out_rega, out_regb, out_regd;
  logic [1:0] occupancy;
`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] perf_haz_cycles, perf_full_cycles;
`endif

  int errors = 0, checks = 0, cyc = 0, block_until = 0;
  int unsigned m_haz = 0, m_full = 0;
  ent_t q[$];

  decode_issue_buffer #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .HAZ_STALL(HZ)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rega_data(in_rega_data), .in_regb_data(in_regb_data), .in_imm(in_imm),
    .in_rega(in_rega), .in_regb(in_regb), .in_regd(in_regd), .in_uses_b(in_uses_b),
    .in_ctrl(in_ctrl), .ex_valid(ex_valid), .ex_mem_r(ex_mem_r), .ex_regd(ex_regd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rega_data(out_rega_data), .out_regb_data(out_regb_data), .out_imm(out_imm),
    .out_rega(out_rega), .out_regb(out_regb), .out_regd(out_regd), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef DECODE_ISSUE_PERF_EN
    , .perf_haz_cycles(perf_haz_cycles), .perf_full_cycles(perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [XLEN-1:0] pc);
    in_pc        = pc;
    in_rega_data = $urandom;
    in_regb_data = $urandom;
    in_imm       = $urandom;
    in_regd      = RA_W'($urandom_range(0, 31));
    in_ctrl      = CTRL_W'($urandom);
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic cycle();
    logic haz, rdy, push, pop, start;
    ent_t e, h;
    #1;
    haz = in_valid && ex_valid && ex_mem_r && (ex_regd != 0) &&
          ((ex_regd == in_rega) || (in_uses_b && (ex_regd == in_regb)));
    rdy = (q.size() < 2) && !haz && (cyc >= block_until);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_pc", 64'(out_pc), 64'(h.pc));
      chk("out_rega_data", 64'(out_rega_data), 64'(h.a_data));
      chk("out_regb_data", 64'(out_regb_data), 64'(h.b_data));
      chk("out_imm", 64'(out_imm), 64'(h.imm));
      chk("out_regs_ctrl", 64'({out_rega, out_regb, out_regd, out_ctrl}),
          64'({h.ra, h.rb, h.rd, h.ctrl}));
    end
`ifdef DECODE_ISSUE_PERF_EN
    chk("perf_haz_cycles", 64'(perf_haz_cycles), 64'(m_haz));
    chk("perf_full_cycles", 64'(perf_full_cycles), 64'(m_full));
`endif
    push  = in_valid && rdy;
    pop   = (q.size() != 0) && out_ready;
    start = haz && (cyc >= block_until);
    if (in_valid && !rdy && (haz || (cyc < block_until))) m_haz++;
    if (in_valid && (q.size() == 2)) m_full++;
    e = '{in_pc, in_rega_data, in_regb_data, in_imm, in_rega, in_regb, in_regd, in_ctrl};
    @(posedge clk);
    if (flush) begin
      q.delete();
      block_until = cyc + 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (start) block_until = cyc + HZ;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
`ifdef DECODE_ISSUE_PERF_EN
    chk("rst_perf_haz", 64'(perf_haz_cycles), 64'd0);
    chk("rst_perf_full", 64'(perf_full_cycles), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    block_until = cyc;
    m_haz = 0;
    m_full = 0;
  endtask

  initial begin
    int stalls;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_uses_b = 1'b1;
    in_rega = '0; in_regb = '0; ex_valid = 1'b0; ex_mem_r = 1'b0; ex_regd = '0;
    set_fields(32'h0);
    #3;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_occupancy", 64'(occupancy), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd0);
    chk("init_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    cycle();

    // Back-pressure: third push refused until a slot frees.
    in_valid = 1'b1; out_ready = 1'b0; in_rega = 5'd1; in_regb = 5'd2;
    set_fields(32'h4); cycle();
    set_fields(32'h8); cycle();
    set_fields(32'hC);
    #1 chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    cycle();
    out_ready = 1'b1;
    #1 chk("bp_head_pc_first", 64'(out_pc), 64'h4);
    cycle();
    #1 chk("bp_head_pc_second", 64'(out_pc), 64'h8);
    chk("bp_third_accepted", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0; cycle(); cycle();

    // Streaming at full rate.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_fields(32'h100 + 32'(4 * i));
      cycle();
      if (i > 0) chk("stream_occupancy", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0; cycle();

    // Flush with a full buffer and a push in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(32'h200); cycle();
    set_fields(32'h204); cycle();
    set_fields(32'h208); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_out_pc", 64'(out_pc), 64'd0);
    cycle();
    out_ready = 1'b1; cycle(); cycle();

    // Load-use: exactly HZ blocked cycles, then accepted once the load retires.
    in_valid = 1'b1; in_rega = 5'd5; in_regb = 5'd1; in_uses_b = 1'b1;
    ex_valid = 1'b1; ex_mem_r = 1'b1; ex_regd = 5'd5;
    set_fields(32'h300);
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      #1 if (!in_ready) stalls++;
      cycle();
    end
    ex_mem_r = 1'b0;
    #1 chk("loaduse_stall_count", 64'(stalls), 64'd2);
    chk("loaduse_accept", 64'(in_ready), 64'd1);
    cycle();
    ex_mem_r = 1'b1; ex_regd = 5'd0; in_rega = 5'd0; set_fields(32'h304);
    #1 chk("loaduse_r0_no_stall", 64'(in_ready), 64'd1);
    cycle();
    ex_regd = 5'd5; in_rega = 5'd1; in_regb = 5'd5; in_uses_b = 1'b0; set_fields(32'h308);
    #1 chk("loaduse_imm_no_stall", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0; ex_valid = 1'b0; ex_mem_r = 1'b0; cycle(); cycle();

    // Mid-stream async reset, then the first push after release must come through intact.
    out_ready = 1'b0; in_valid = 1'b1; in_uses_b = 1'b1; in_rega = 5'd1; in_regb = 5'd2;
    set_fields(32'h400); cycle();
    set_fields(32'h404); cycle();
    async_reset();
    set_fields(32'h500); cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("post_reset_pc", 64'(out_pc), 64'h500);
    cycle(); cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      set_fields($urandom);
      in_rega   = RA_W'($urandom_range(0, 3));
      in_regb   = RA_W'($urandom_range(0, 3));
      in_uses_b = 1'($urandom_range(0, 1));
      ex_valid  = 1'($urandom_range(0, 1));
      ex_mem_r  = 1'($urandom_range(0, 1));
      ex_regd   = RA_W'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
      if (i == 300) async_reset();
    end
    flush = 1'b0; in_valid = 1'b0; cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
